// File: rtl/disp_scan.sv
// Time-multiplexed 4-digit (parameterisable) seven-segment scanner.
// Feeds one nibble, a blanking bit and a point bit per digit period to an
// MC14495-style decoder and drives the matching active-low anode. Display
// data is double-buffered: updates are staged, then copied into a shadow
// register only at the frame boundary. Optional leading-zero suppression.
module disp_scan #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     le_mask,
  input  logic                  blank_lead,
  input  logic                  update,
  output logic [DIGITS-1:0]     an,
  output logic [3:0]            hex_o,
  output logic                  le_o,
  output logic                  point_o,
  output logic                  frame_tick
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  // Prescaler and digit index
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic          last_cnt;
  logic          boundary;

  // Staging (written by update) and shadow (displayed) copies
  logic [DIGITS-1:0][3:0] stg_hex, sh_hex, sh_hex_n;
  logic [DIGITS-1:0]      stg_pt, sh_pt, sh_pt_n;
  logic [DIGITS-1:0]      stg_le, sh_le, sh_le_n;
  logic                   pending, pending_n;

  // Leading-zero suppression per digit
  logic [DIGITS-1:0]      sup;

  // Next-state output values
  logic [DIGITS-1:0]      an_n;
  logic [3:0]             hex_n;
  logic                   le_n;
  logic                   point_n;
  logic                   tick_n;

  // Next prescaler count and digit index
  always_comb begin
    last_cnt = (cnt == CNT_LAST);
    boundary = last_cnt && (idx == IDX_LAST);
    cnt_n    = last_cnt ? '0 : cnt + CW'(1);
    idx_n    = idx;
    if (last_cnt) begin
      idx_n = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  // Shadow reload at frame boundary; an update in the boundary cycle itself
  // bypasses staging so it is not lost to the one-cycle staging delay.
  always_comb begin
    sh_hex_n  = sh_hex;
    sh_pt_n   = sh_pt;
    sh_le_n   = sh_le;
    pending_n = pending;
    if (update) begin
      pending_n = 1'b1;
    end
    if (boundary) begin
      if (update) begin
        sh_hex_n = hexs;
        sh_pt_n  = points;
        sh_le_n  = le_mask;
      end else if (pending) begin
        sh_hex_n = stg_hex;
        sh_pt_n  = stg_pt;
        sh_le_n  = stg_le;
      end
      pending_n = 1'b0;
    end
  end

  // Suppress digit i when blanking is on and it and every higher digit are zero
  always_comb begin
    logic zero_run;
    sup      = '0;
    zero_run = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (sh_hex_n[i] == 4'h0);
      sup[i]   = blank_lead && zero_run;
    end
  end

  // Output values for the upcoming cycle; all anodes off on the first cycle
  // of each digit period so segment data switches while nothing is lit.
  always_comb begin
    an_n = '1;
    if (cnt_n != '0) begin
      an_n[idx_n] = 1'b0;
    end
    hex_n   = sh_hex_n[idx_n];
    le_n    = sh_le_n[idx_n] | sup[idx_n];
    point_n = sh_pt_n[idx_n];
    tick_n  = (cnt_n == '0) && (idx_n == '0);
  end

  // Prescaler, index and pending flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      pending <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      idx     <= idx_n;
      pending <= pending_n;
    end
  end

  // Staging register captures every update strobe; the last one wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_hex <= '0;
      stg_pt  <= '0;
      stg_le  <= '0;
    end else if (update) begin
      stg_hex <= hexs;
      stg_pt  <= points;
      stg_le  <= le_mask;
    end
  end

  // Shadow register holding the frame currently on display
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_hex <= '0;
      sh_pt  <= '0;
      sh_le  <= '0;
    end else begin
      sh_hex <= sh_hex_n;
      sh_pt  <= sh_pt_n;
      sh_le  <= sh_le_n;
    end
  end

  // Registered decoder and anode outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= '1;
      hex_o      <= '0;
      le_o       <= 1'b1;
      point_o    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_n;
      hex_o      <= hex_n;
      le_o       <= le_n;
      point_o    <= point_n;
      frame_tick <= tick_n;
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Self-checking bench for disp_scan (DIGITS=4, REFRESH_DIV=4).
// A frame-level model tracks cycles since reset and the displayed frame;
// each cycle's outputs are derived from the frame position arithmetically.
module tb_disp_scan;

  localparam int D     = 4;
  localparam int RD    = 4;
  localparam int FRAME = D * RD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   hexs = '0;
  logic [3:0]    points = '0;
  logic [3:0]    le_mask = '0;
  logic          blank_lead = 1'b0;
  logic          update = 1'b0;
  logic [3:0]    an;
  logic [3:0]    hex_o;
  logic          le_o;
  logic          point_o;
  logic          frame_tick;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  disp_scan #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .hexs(hexs), .points(points), .le_mask(le_mask),
    .blank_lead(blank_lead), .update(update), .an(an), .hex_o(hex_o),
    .le_o(le_o), .point_o(point_o), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Model state: edges since reset release, displayed frame, latest request
  int          k = 0;
  logic [15:0] m_hex = '0, q_hex = '0;
  logic [3:0]  m_pt = '0, q_pt = '0;
  logic [3:0]  m_le = '0, q_le = '0;
  logic        q_valid = 1'b0;
  logic        bl_s = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0; m_hex = '0; m_pt = '0; m_le = '0;
      q_hex = '0; q_pt = '0; q_le = '0; q_valid = 1'b0; bl_s = 1'b0;
    end else begin
      if (update) begin
        q_hex = hexs; q_pt = points; q_le = le_mask; q_valid = 1'b1;
      end
      if ((k % FRAME) == FRAME - 1 && q_valid) begin
        m_hex = q_hex; m_pt = q_pt; m_le = q_le; q_valid = 1'b0;
      end
      bl_s = blank_lead;
      k = k + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at t=%0t k=%0d: got %0h, expected %0h", name, $time, k, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      int pos, d, e_an, e_hex, e_le, e_pt, e_ft;
      pos = k % FRAME;
      d   = pos / RD;
      if (k == 0) begin
        e_an = 4'hF; e_hex = 0; e_le = 1; e_pt = 0; e_ft = 0;
      end else begin
        e_an  = (pos % RD == 0) ? 4'hF : (4'hF ^ (1 << d));
        e_hex = (m_hex >> (4 * d)) & 4'hF;
        e_pt  = (m_pt >> d) & 1;
        e_le  = (m_le >> d) & 1;
        if (bl_s && d >= 1 && (m_hex >> (4 * d)) == 0) e_le = 1;
        e_ft  = (pos == 0) ? 1 : 0;
      end
      check("an", an, e_an);
      check("hex_o", hex_o, e_hex);
      check("le_o", le_o, e_le);
      check("point_o", point_o, e_pt);
      check("frame_tick", frame_tick, e_ft);
    end
  end

  // Advance to the next negedge where the frame position equals p
  task automatic wait_pos(input int p);
    int n = 0;
    @(negedge clk);
    while ((k % FRAME) != p && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if ((k % FRAME) != p) check("wait_pos_timeout", k % FRAME, p);
  endtask

  task automatic pulse_update(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l);
    hexs = h; points = p; le_mask = l; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  function automatic logic [15:0] rand_hexs();
    logic [15:0] v = '0;
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 1) == 1) v[4*i +: 4] = 4'($urandom_range(1, 15));
    return v;
  endfunction

  initial begin
    int an_seq [16] = '{4'hF,4'hE,4'hE,4'hE,4'hF,4'hD,4'hD,4'hD,
                        4'hF,4'hB,4'hB,4'hB,4'hF,4'h7,4'h7,4'h7};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    check("lit_an_0", an, an_seq[0]);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check("lit_an_seq", an, an_seq[i]);
      check("lit_le_zero", le_o, 0);
      check("lit_hex_zero", hex_o, 0);
    end

    // Mid-frame update: old data until wrap, then 4,3,2,1
    wait_pos(6);
    pulse_update(16'h1234, 4'h0, 4'h0);
    wait_pos(9);  check("lit_old_d2", hex_o, 0);
    wait_pos(0);  check("lit_tick", frame_tick, 1); check("lit_guard", an, 4'hF);
    wait_pos(1);  check("lit_1234_d0", hex_o, 4);
    wait_pos(5);  check("lit_1234_d1", hex_o, 3);
    wait_pos(9);  check("lit_1234_d2", hex_o, 2);
    wait_pos(13); check("lit_1234_d3", hex_o, 1);

    // Update in the boundary cycle takes the bypass path
    wait_pos(15);
    pulse_update(16'hABCD, 4'h0, 4'h0);
    wait_pos(1);  check("lit_bypass_d0", hex_o, 4'hD);
    wait_pos(5);  check("lit_bypass_d1", hex_o, 4'hC);
    wait_pos(9);  check("lit_bypass_d2", hex_o, 4'hB);
    wait_pos(13); check("lit_bypass_d3", hex_o, 4'hA);

    // Leading-zero suppression
    blank_lead = 1'b1;
    pulse_update(16'h0070, 4'h0, 4'h0);
    wait_pos(1);  check("lit_lz_d0", le_o, 0);
    wait_pos(5);  check("lit_lz_d1", le_o, 0);
    wait_pos(9);  check("lit_lz_d2", le_o, 1);
    wait_pos(13); check("lit_lz_d3", le_o, 1);
    pulse_update(16'h0000, 4'h0, 4'h0);
    wait_pos(0);
    wait_pos(1);  check("lit_z_d0", le_o, 0); check("lit_z_hex", hex_o, 0);
    wait_pos(5);  check("lit_z_d1", le_o, 1);
    blank_lead = 1'b0;

    // Forced blank and decimal point
    pulse_update(16'h1111, 4'b0010, 4'b0100);
    wait_pos(0);
    wait_pos(5);  check("lit_pt_d1", point_o, 1); check("lit_le_d1", le_o, 0);
    wait_pos(9);  check("lit_le_d2", le_o, 1);   check("lit_pt_d2", point_o, 0);

    // Asynchronous reset mid-frame with an update pending
    wait_pos(6);
    pulse_update(16'h5555, 4'hF, 4'h0);
    wait_pos(9);
    #2 rst = 1'b1;
    #1;
    check("lit_rst_an", an, 4'hF);
    check("lit_rst_hex", hex_o, 0);
    check("lit_rst_le", le_o, 1);
    check("lit_rst_pt", point_o, 0);
    check("lit_rst_ft", frame_tick, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_pos(15);
    wait_pos(1);
    check("lit_rst_discard_hex", hex_o, 0);
    check("lit_rst_discard_pt", point_o, 0);

    // Randomized traffic, including back-to-back and boundary updates
    for (int c = 0; c < 20 * FRAME; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        hexs = rand_hexs(); points = 4'($urandom); le_mask = 4'($urandom);
        update = 1'b1;
      end else begin
        update = 1'b0;
      end
      if ($urandom_range(0, 29) == 0) blank_lead = ~blank_lead;
      @(negedge clk);
    end
    update = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
